note_keymap_ctrl: RTL
=====================

Name: note_keymap_ctrl

Overview:
Parametrised successor to the fixed 7-key set-mode logic. It teaches a user-defined mapping from physical note keys to note indices: in set mode, each submit press assigns the single held key to the next note slot. Writes go to a shadow table that is committed atomically on completion, or discarded if set mode is left early. In play modes it provides a registered key-to-note lookup for the tone generator and display path.

Parameters:
NUM_KEYS, 7, number of note keys and note slots (2..16); localparam IDX_W = $clog2(NUM_KEYS)
MODE_W, 3, width of mode input
SET_MODE, 3'd1, mode value that selects set (teach) mode

Ports:
clk  in  1  system clock (100 MHz board clock)
rst_n  in  1  reset; synchronous, active-low
mode  in  MODE_W  current global mode
submit  in  1  debounced submit button level
note_key  in  NUM_KEYS  note key levels, bit i = key i held
lookup_key  in  NUM_KEYS  key vector to translate (play path)
lookup_note  out  IDX_W  mapped note index for lookup_key
lookup_valid  out  1  lookup_key was exactly one-hot
setting  out  1  teach session in progress (ARMED)
slot  out  IDX_W  next note slot to be assigned
done  out  1  session completed and committed
err_dup  out  1  one-cycle pulse: key already assigned this session
err_multi  out  1  one-cycle pulse: zero or more than one key held at submit

Behaviour:
- Reset (rst_n=0 at posedge clk): active table = identity (key i -> note i); shadow table and assigned[] cleared; state IDLE; submit_q=1 (a held submit gives no edge after reset); mode_q=~SET_MODE; all outputs 0.
- sub_edge = submit & ~submit_q. enter = (mode==SET_MODE) & (mode_q!=SET_MODE). leave = (mode!=SET_MODE) & (mode_q==SET_MODE).
- States:
  - IDLE: on enter -> ARMED, slot=0, assigned[]=0. sub_edge in the entry cycle is ignored.
  - ARMED: on sub_edge:
    - popcount(note_key)!=1 -> err_multi pulse, no state change.
    - key k with assigned[k]=1 -> err_dup pulse, no change.
    - otherwise shadow[k]=slot, assigned[k]=1. If slot==NUM_KEYS-1 -> DONE and copy shadow (including this write) into the active table on the same edge; else slot+1.
  - DONE: further sub_edges ignored, no error pulses.
  - leave from ARMED or DONE -> IDLE. Leaving ARMED aborts: shadow is discarded and the active table is unchanged.
- leave and sub_edge in the same cycle: leave wins, no write.
- Outputs:
  - setting = (state==ARMED).
  - done = (state==DONE), held until leave.
  - slot holds NUM_KEYS-1 in DONE and resets to 0 on IDLE.
- Error pulses are registered and last exactly one cycle, asserted the cycle after sub_edge.
- Lookup: registered, 1-cycle latency, active in every mode.
  - lookup_key one-hot at bit k -> next cycle lookup_valid=1, lookup_note=active[k].
  - otherwise lookup_valid=0, lookup_note=0.
  - A lookup in the commit cycle returns the old mapping; the new mapping is visible from the next cycle.
- Reset mid-session: immediate return to the reset state; any in-progress teach is lost and the active table returns to identity.
- Mode values other than SET_MODE have no effect beyond leave detection.

Test Plan:
- Reset, lookup_key=7'b0000100 -> one cycle later lookup_valid=1, lookup_note=2; lookup_key=7'b0000110 -> lookup_valid=0, lookup_note=0.
- mode=1; submit pulses with note_key one-hot 6,5,4,3,2,1,0 in turn -> slot steps 0..6, then done=1, setting=0; afterwards lookup of key 6 -> 0 and key 0 -> 6.
- In ARMED at slot=2, submit with key 3 (already assigned) -> err_dup high exactly 1 cycle, slot stays 2; submit with note_key=0 -> err_multi 1 cycle, slot 2.
- Teach 3 keys, then mode=0 -> IDLE, setting=0; lookups still return the previous full mapping. Re-enter mode=1 -> slot=0, key 0 accepted again.
- submit held high through reset release and through the set-mode entry cycle -> no assignment; release and press again -> assignment at slot 0.
- NUM_KEYS=12 instance (IDX_W=4): full teach in reverse order -> done after 12 submits, lookup key 11 -> 0; rst_n=0 mid-session -> identity mapping restored.

Source files
------------

// File: rtl/note_keymap_ctrl_if.sv
// note_keymap_ctrl_if: groups the mode/submit/key inputs and the lookup and
// teach-status outputs of note_keymap_ctrl into a single bundle.
//   master : drives mode, submit, note_key, lookup_key; reads all status
//   slave  : the keymap controller itself
// Signals:
//   mode[MODE_W]        current global mode
//   submit              debounced submit button level
//   note_key[NUM_KEYS]  held note keys (bit i = key i)
//   lookup_key[NUM_KEYS] key vector to translate on the play path
//   lookup_note[IDX_W]  mapped note index (registered)
//   lookup_valid        lookup_key was exactly one-hot
//   setting             teach session in progress
//   slot[IDX_W]         next note slot to be assigned
//   done                session completed and committed
//   err_dup / err_multi one-cycle error pulses
interface note_keymap_ctrl_if #(
    parameter int NUM_KEYS = 7,
    parameter int MODE_W   = 3
) ();
    localparam int IDX_W = $clog2(NUM_KEYS);

    logic [MODE_W-1:0]   mode;
    logic                submit;
    logic [NUM_KEYS-1:0] note_key;
    logic [NUM_KEYS-1:0] lookup_key;
    logic [IDX_W-1:0]    lookup_note;
    logic                lookup_valid;
    logic                setting;
    logic [IDX_W-1:0]    slot;
    logic                done;
    logic                err_dup;
    logic                err_multi;

    modport master (
        output mode, submit, note_key, lookup_key,
        input  lookup_note, lookup_valid, setting, slot, done, err_dup, err_multi
    );

    modport slave (
        input  mode, submit, note_key, lookup_key,
        output lookup_note, lookup_valid, setting, slot, done, err_dup, err_multi
    );
endinterface

// File: rtl/note_keymap_ctrl.sv
// note_keymap_ctrl: teaches a user-defined key -> note mapping. In set mode
// every submit press assigns the single held key to the next note slot in a
// shadow table; the shadow is committed to the active table on the edge that
// fills the last slot, and dropped if set mode is left first. The active
// table drives a registered one-cycle key -> note lookup in every mode.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (identity mapping, IDLE)
//   bus    note_keymap_ctrl_if.slave (mode/submit/keys in, lookup/status out)
module note_keymap_ctrl #(
    parameter int                NUM_KEYS = 7,
    parameter int                MODE_W   = 3,
    parameter logic [MODE_W-1:0] SET_MODE = 3'd1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    note_keymap_ctrl_if.slave    bus
);
    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_KEYS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Position of the set bit; only meaningful when the vector is one-hot.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_KEYS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return ($countones(v) == 1);
    endfunction

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    slot_q, slot_d;
    logic [NUM_KEYS-1:0] assigned_q, assigned_d;
    logic [IDX_W-1:0]    shadow_q [NUM_KEYS];
    logic [IDX_W-1:0]    shadow_d [NUM_KEYS];
    logic [IDX_W-1:0]    active_q [NUM_KEYS];
    logic [IDX_W-1:0]    active_d [NUM_KEYS];
    logic                submit_q;
    logic [MODE_W-1:0]   mode_q;
    logic                err_dup_q, err_dup_d;
    logic                err_multi_q, err_multi_d;
    logic                lookup_valid_q, lookup_valid_d;
    logic [IDX_W-1:0]    lookup_note_q, lookup_note_d;

    logic                sub_edge, enter, leave;
    logic [IDX_W-1:0]    key_k;

    assign sub_edge = bus.submit & ~submit_q;
    assign enter    = (bus.mode == SET_MODE) && (mode_q != SET_MODE);
    assign leave    = (bus.mode != SET_MODE) && (mode_q == SET_MODE);
    assign key_k    = onehot_idx(bus.note_key);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        assigned_d  = assigned_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        err_dup_d   = 1'b0;
        err_multi_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A submit edge coinciding with entry is deliberately ignored.
                if (enter) begin
                    state_d    = ST_ARMED;
                    slot_d     = '0;
                    assigned_d = '0;
                end
            end
            ST_ARMED: begin
                // Leaving has priority over a simultaneous submit; the shadow
                // is simply never committed, which is the abort.
                if (leave) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end else if (sub_edge) begin
                    if (!is_onehot(bus.note_key)) begin
                        err_multi_d = 1'b1;
                    end else if (assigned_q[key_k]) begin
                        err_dup_d = 1'b1;
                    end else begin
                        shadow_d[key_k]   = slot_q;
                        assigned_d[key_k] = 1'b1;
                        if (slot_q == LAST_SLOT) begin
                            // Commit includes the write made on this same edge.
                            state_d  = ST_DONE;
                            active_d = shadow_d;
                        end else begin
                            slot_d = slot_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (leave) begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase

        // Lookup reads the pre-commit table, so the new mapping shows a cycle later.
        lookup_valid_d = is_onehot(bus.lookup_key);
        lookup_note_d  = lookup_valid_d ? active_q[onehot_idx(bus.lookup_key)] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            slot_q         <= '0;
            assigned_q     <= '0;
            submit_q       <= 1'b1;
            mode_q         <= ~SET_MODE;
            err_dup_q      <= 1'b0;
            err_multi_q    <= 1'b0;
            lookup_valid_q <= 1'b0;
            lookup_note_q  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                active_q[i] <= IDX_W'(i);
                shadow_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            assigned_q     <= assigned_d;
            submit_q       <= bus.submit;
            mode_q         <= bus.mode;
            err_dup_q      <= err_dup_d;
            err_multi_q    <= err_multi_d;
            lookup_valid_q <= lookup_valid_d;
            lookup_note_q  <= lookup_note_d;
            active_q       <= active_d;
            shadow_q       <= shadow_d;
        end
    end

    assign bus.setting      = (state_q == ST_ARMED);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.slot         = slot_q;
    assign bus.err_dup      = err_dup_q;
    assign bus.err_multi    = err_multi_q;
    assign bus.lookup_valid = lookup_valid_q;
    assign bus.lookup_note  = lookup_note_q;
endmodule
